// File: rtl/ip4_cam_pkg.sv
// Shared types for the IP4 CAM configuration controller.
package ip4_cam_pkg;

    localparam int unsigned IP4_ADDR_W = 32;

    typedef struct packed {
        logic [IP4_ADDR_W-1:0] addr;
        logic                  must_match;
    } cam_entry_t;

    typedef enum logic [0:0] {
        CFG_IDLE,
        CFG_PENDING
    } cfg_state_t;

endpackage

// File: rtl/ip4_cam_cfg_ctrl_if.sv
// Single-entry CAM configuration write channel (valid/ready).
interface ip4_cam_cfg_ctrl_if #(
    parameter int unsigned ID_WIDTH = 4
);
    logic                               cfg_wr_valid;
    logic                               cfg_wr_ready;
    logic [ID_WIDTH-1:0]                cfg_wr_id;
    logic [ip4_cam_pkg::IP4_ADDR_W-1:0] cfg_wr_addr;
    logic                               cfg_wr_must_match;

    modport master (
        output cfg_wr_valid,
        output cfg_wr_id,
        output cfg_wr_addr,
        output cfg_wr_must_match,
        input  cfg_wr_ready
    );

    modport slave (
        input  cfg_wr_valid,
        input  cfg_wr_id,
        input  cfg_wr_addr,
        input  cfg_wr_must_match,
        output cfg_wr_ready
    );
endinterface

// File: rtl/axis_pkt_boundary_mon.sv
// Passive AXI-Stream monitor: tracks packet state and flags cycles where a
// table update cannot split a packet.
module axis_pkt_boundary_mon (
    input  logic aclk,
    input  logic aresetn,
    input  logic tvalid,
    input  logic tready,
    input  logic tlast,
    output logic commit_ok
);
    logic valid_beat;
    logic last_beat;
    logic in_packet_q;

    assign valid_beat = tvalid & tready;
    assign last_beat  = valid_beat & tlast;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            in_packet_q <= 1'b0;
        end else if (last_beat) begin
            in_packet_q <= 1'b0;
        end else if (valid_beat) begin
            in_packet_q <= 1'b1;
        end
    end

    // Updating on the last beat lands the new table before the next packet's first beat.
    assign commit_ok = last_beat | (~in_packet_q & ~valid_beat);

endmodule

// File: rtl/ip4_cam_cfg_ctrl.sv
// IP4 destination CAM owner: serialises config writes and commits them only at
// packet boundaries. Optional readback port enabled by IP4_CAM_READBACK_EN.
module ip4_cam_cfg_ctrl
    import ip4_cam_pkg::*;
#(
    parameter int unsigned AXIS_ID_WIDTH    = 4,
    parameter int unsigned WAIT_CNT_WIDTH   = 16,
    parameter bit          RESET_MUST_MATCH = 1'b1,
    localparam int unsigned NUM_AXIS_ID     = 2 ** AXIS_ID_WIDTH,
    localparam int unsigned EFF_ID_WIDTH    = (AXIS_ID_WIDTH > 0) ? AXIS_ID_WIDTH : 1
) (
    input  logic                                  aclk,
    input  logic                                  aresetn,
    input  logic                                  mon_tvalid,
    input  logic                                  mon_tready,
    input  logic                                  mon_tlast,
    ip4_cam_cfg_ctrl_if.slave                     cfg,
    output logic [NUM_AXIS_ID-1:0][IP4_ADDR_W-1:0] ip4_addresses,
    output logic [NUM_AXIS_ID-1:0]                ip4_cam_must_match,
    output logic                                  cfg_commit,
    output logic [WAIT_CNT_WIDTH-1:0]             cfg_wait_cycles
`ifdef IP4_CAM_READBACK_EN
    ,
    input  logic [EFF_ID_WIDTH-1:0]               rd_id,
    output logic [IP4_ADDR_W-1:0]                 rd_addr,
    output logic                                  rd_must_match
`endif
);
    cfg_state_t                    state_q, state_d;
    cam_entry_t                    pend_q, pend_d;
    logic [EFF_ID_WIDTH-1:0]       pend_id_q, pend_id_d;
    logic [WAIT_CNT_WIDTH-1:0]     wait_q, wait_d;
    logic                          commit_q, commit_d;
    logic                          apply;
    logic                          commit_ok;
    cam_entry_t [NUM_AXIS_ID-1:0]  table_q;

    axis_pkt_boundary_mon u_mon (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .tvalid    (mon_tvalid),
        .tready    (mon_tready),
        .tlast     (mon_tlast),
        .commit_ok (commit_ok)
    );

    assign cfg.cfg_wr_ready = (state_q == CFG_IDLE);

    always_comb begin
        state_d   = state_q;
        pend_d    = pend_q;
        pend_id_d = pend_id_q;
        wait_d    = wait_q;
        commit_d  = 1'b0;
        apply     = 1'b0;
        unique case (state_q)
            CFG_IDLE: begin
                if (cfg.cfg_wr_valid) begin
                    pend_d.addr       = cfg.cfg_wr_addr;
                    pend_d.must_match = cfg.cfg_wr_must_match;
                    pend_id_d         = cfg.cfg_wr_id;
                    wait_d            = '0;
                    state_d           = CFG_PENDING;
                end
            end
            CFG_PENDING: begin
                if (wait_q != '1) begin
                    wait_d = wait_q + WAIT_CNT_WIDTH'(1);
                end
                if (commit_ok) begin
                    apply    = 1'b1;
                    commit_d = 1'b1;
                    state_d  = CFG_IDLE;
                end
            end
            default: state_d = CFG_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= CFG_IDLE;
            pend_q    <= '0;
            pend_id_q <= '0;
            wait_q    <= '0;
            commit_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pend_q    <= pend_d;
            pend_id_q <= pend_id_d;
            wait_q    <= wait_d;
            commit_q  <= commit_d;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < NUM_AXIS_ID; i++) begin
                table_q[i].addr       <= '0;
                table_q[i].must_match <= RESET_MUST_MATCH;
            end
        end else if (apply) begin
            table_q[pend_id_q] <= pend_q;
        end
    end

    always_comb begin
        ip4_addresses      = '0;
        ip4_cam_must_match = '0;
        for (int i = 0; i < NUM_AXIS_ID; i++) begin
            ip4_addresses[i]      = table_q[i].addr;
            ip4_cam_must_match[i] = table_q[i].must_match;
        end
    end

    assign cfg_commit      = commit_q;
    assign cfg_wait_cycles = wait_q;

`ifdef IP4_CAM_READBACK_EN
    cam_entry_t rd_q;

    // Reads the committed table, so a read in the commit cycle sees the old entry.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rd_q <= '0;
        end else begin
            rd_q <= table_q[rd_id];
        end
    end

    assign rd_addr       = rd_q.addr;
    assign rd_must_match = rd_q.must_match;
`endif

endmodule
